// File: rtl/wired_tl_pkg.sv
// Shared TileLink types and constants for the dcache bus adapter.
// Payload structs, opcode encodings and the source IDs owned by each state machine.
package wired_tl_pkg;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [1:0]  source;
    logic [31:0] address;
    logic [3:0]  mask;
    logic [31:0] data;
  } tl_a_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [2:0]  size;
    logic [1:0]  source;
    logic [1:0]  sink;
    logic        denied;
    logic [31:0] data;
    logic        corrupt;
  } tl_d_t;

  localparam logic [2:0] A_PUT_FULL      = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL   = 3'd1;
  localparam logic [2:0] A_ARITHMETIC    = 3'd2;
  localparam logic [2:0] A_LOGICAL       = 3'd3;
  localparam logic [2:0] A_GET           = 3'd4;
  localparam logic [2:0] A_HINT          = 3'd5;
  localparam logic [2:0] A_ACQUIRE_BLOCK = 3'd6;
  localparam logic [2:0] A_ACQUIRE_PERM  = 3'd7;

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_HINT_ACK        = 3'd2;
  localparam logic [2:0] D_GRANT           = 3'd4;
  localparam logic [2:0] D_GRANT_DATA      = 3'd5;
  localparam logic [2:0] D_RELEASE_ACK     = 3'd6;

  localparam logic [1:0] TL_SRC_ACQ = 2'd0;
  localparam logic [1:0] TL_SRC_UNC = 2'd1;
  localparam logic [1:0] TL_SRC_INV = 2'd2;

  typedef enum logic {
    OWN_ACQ = 1'b0,
    OWN_UNC = 1'b1
  } a_owner_e;

endpackage

// File: rtl/wired_tl_chan_arb_if.sv
// Bundle of the requester A channels, the bus A/D channels and the D consumer handshakes.
// slave is the arbiter's view; master is the surrounding adapter's view.
interface wired_tl_chan_arb_if;
  import wired_tl_pkg::*;

  logic  acq_a_valid;
  logic  acq_a_ready;
  tl_a_t acq_a;
  logic  unc_a_valid;
  logic  unc_a_ready;
  tl_a_t unc_a;
  logic  tl_a_valid;
  logic  tl_a_ready;
  tl_a_t tl_a;
  logic  tl_d_valid;
  logic  tl_d_ready;
  tl_d_t tl_d;
  logic  inv_d_valid;
  logic  inv_d_ready;
  logic  acq_d_valid;
  logic  acq_d_ready;
  logic  unc_d_valid;
  logic  unc_d_ready;
  tl_d_t d_o;
  logic  d_last_o;
  logic  [1:0] err_o;

  modport slave (
    input  acq_a_valid, acq_a, unc_a_valid, unc_a, tl_a_ready,
    input  tl_d_valid, tl_d, inv_d_ready, acq_d_ready, unc_d_ready,
    output acq_a_ready, unc_a_ready, tl_a_valid, tl_a, tl_d_ready,
    output inv_d_valid, acq_d_valid, unc_d_valid, d_o, d_last_o, err_o
  );

  modport master (
    output acq_a_valid, acq_a, unc_a_valid, unc_a, tl_a_ready,
    output tl_d_valid, tl_d, inv_d_ready, acq_d_ready, unc_d_ready,
    input  acq_a_ready, unc_a_ready, tl_a_valid, tl_a, tl_d_ready,
    input  inv_d_valid, acq_d_valid, unc_d_valid, d_o, d_last_o, err_o
  );

endinterface

// File: rtl/wired_tl_d_beat_cnt.sv
// D-channel beat counter: flags the final beat of each message and detects a
// source change in the middle of a multi-beat burst.
module wired_tl_d_beat_cnt
  import wired_tl_pkg::*;
#(
  parameter int BEAT_BYTES = 4,
  parameter int LINE_BYTES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_fire,
  input  logic [2:0] d_opcode,
  input  logic [2:0] d_size,
  input  logic [1:0] d_source,
  output logic       d_last,
  output logic       d_mismatch
);

  localparam int         MULTI_BEATS = LINE_BYTES / BEAT_BYTES;
  localparam logic [2:0] LINE_SIZE   = 3'($clog2(LINE_BYTES));
  localparam logic [1:0] MULTI_LAST  = 2'(MULTI_BEATS - 1);

  logic [1:0] d_cnt;
  logic [1:0] d_src_q;
  logic [1:0] cnt_eff;
  logic [1:0] last_idx;
  logic       multi;

  // A mismatching beat is treated as the first beat of a fresh message.
  always_comb begin
    multi      = ((d_opcode == D_ACCESS_ACK_DATA) || (d_opcode == D_GRANT_DATA)) &&
                 (d_size == LINE_SIZE);
    last_idx   = multi ? MULTI_LAST : 2'd0;
    d_mismatch = (d_cnt != 2'd0) && (d_source != d_src_q);
    cnt_eff    = d_mismatch ? 2'd0 : d_cnt;
    d_last     = (cnt_eff == last_idx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_cnt   <= 2'd0;
      d_src_q <= 2'd0;
    end else if (d_fire) begin
      d_cnt <= d_last ? 2'd0 : cnt_eff + 2'd1;
      if ((cnt_eff == 2'd0) && multi) begin
        d_src_q <= d_source;
      end
    end
  end

endmodule

// File: rtl/wired_tl_chan_arb.sv
// Merges the acq and unc A requests onto the bus A channel (acq first, grant held
// across back-pressure) and steers D beats to inv/acq/unc by source.
module wired_tl_chan_arb
  import wired_tl_pkg::*;
#(
  parameter int         BEAT_BYTES = 4,
  parameter int         LINE_BYTES = 16,
  parameter logic [1:0] SRC_ACQ    = TL_SRC_ACQ,
  parameter logic [1:0] SRC_UNC    = TL_SRC_UNC,
  parameter logic [1:0] SRC_INV    = TL_SRC_INV
) (
  input logic                clk,
  input logic                rst,
  wired_tl_chan_arb_if.slave bus
);

  a_owner_e a_owner;
  logic     a_lock;
  logic     grant_unc;
  logic     a_valid;
  tl_a_t    a_pay;

  // While locked the stalled owner keeps the bus so tl_a stays stable.
  always_comb begin
    grant_unc    = a_lock ? (a_owner == OWN_UNC) : (!bus.acq_a_valid && bus.unc_a_valid);
    a_pay        = grant_unc ? bus.unc_a : bus.acq_a;
    a_pay.source = grant_unc ? SRC_UNC : SRC_ACQ;
    a_valid      = !rst && (grant_unc ? bus.unc_a_valid : bus.acq_a_valid);
  end

  assign bus.tl_a        = a_pay;
  assign bus.tl_a_valid  = a_valid;
  assign bus.acq_a_ready = !rst && !grant_unc && bus.tl_a_ready;
  assign bus.unc_a_ready = !rst && grant_unc && bus.tl_a_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_lock  <= 1'b0;
      a_owner <= OWN_ACQ;
    end else if (a_valid) begin
      a_lock <= !bus.tl_a_ready;
      if (!bus.tl_a_ready) begin
        a_owner <= grant_unc ? OWN_UNC : OWN_ACQ;
      end
    end
  end

  logic [1:0] d_src;
  logic       d_illegal;
  logic       d_rdy;
  logic       d_fire;
  logic       inv_v;
  logic       acq_v;
  logic       unc_v;
  logic       d_last;
  logic       d_mismatch;
  logic [1:0] err_q;

  // Beats from an unknown source are sunk so the bus never wedges on them.
  always_comb begin
    d_src     = bus.tl_d.source;
    inv_v     = 1'b0;
    acq_v     = 1'b0;
    unc_v     = 1'b0;
    d_rdy     = 1'b0;
    d_illegal = 1'b0;
    if (!rst) begin
      if (d_src == SRC_INV) begin
        inv_v = bus.tl_d_valid;
        d_rdy = bus.inv_d_ready;
      end else if (d_src == SRC_ACQ) begin
        acq_v = bus.tl_d_valid;
        d_rdy = bus.acq_d_ready;
      end else if (d_src == SRC_UNC) begin
        unc_v = bus.tl_d_valid;
        d_rdy = bus.unc_d_ready;
      end else begin
        d_illegal = 1'b1;
        d_rdy     = 1'b1;
      end
    end
    d_fire = bus.tl_d_valid && d_rdy;
  end

  wired_tl_d_beat_cnt #(
    .BEAT_BYTES (BEAT_BYTES),
    .LINE_BYTES (LINE_BYTES)
  ) u_beat_cnt (
    .clk        (clk),
    .rst        (rst),
    .d_fire     (d_fire),
    .d_opcode   (bus.tl_d.opcode),
    .d_size     (bus.tl_d.size),
    .d_source   (d_src),
    .d_last     (d_last),
    .d_mismatch (d_mismatch)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 2'b00;
    end else begin
      if (d_fire && d_illegal) err_q[0] <= 1'b1;
      if (d_fire && d_mismatch) err_q[1] <= 1'b1;
    end
  end

  assign bus.tl_d_ready  = d_rdy;
  assign bus.inv_d_valid = inv_v;
  assign bus.acq_d_valid = acq_v;
  assign bus.unc_d_valid = unc_v;
  assign bus.d_o         = bus.tl_d;
  assign bus.d_last_o    = d_last;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_wired_tl_chan_arb.sv
// Self-checking bench for wired_tl_chan_arb: a directed vector table, hand-written
// burst/error sequences, then randomized traffic against a message-level model.
module tb_wired_tl_chan_arb;
  import wired_tl_pkg::*;

  localparam int BEAT_BYTES = 4;
  localparam int LINE_BYTES = 16;

  logic clk;
  logic rst;

  wired_tl_chan_arb_if bus();

  wired_tl_chan_arb #(
    .BEAT_BYTES (BEAT_BYTES),
    .LINE_BYTES (LINE_BYTES),
    .SRC_ACQ    (2'd0),
    .SRC_UNC    (2'd1),
    .SRC_INV    (2'd2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  int n_checks = 0;
  int n_pass   = 0;

  tl_a_t acq_pay;
  tl_a_t unc_pay;

  typedef struct {
    logic acq_v, unc_v, a_rdy;
    logic d_v; logic [2:0] d_op; logic [2:0] d_size; logic [1:0] d_src;
    logic inv_r, acq_r, unc_r;
    logic e_a_v; logic [31:0] e_addr; logic [1:0] e_a_src; logic e_acq_rdy, e_unc_rdy;
    logic e_d_rdy, e_inv_v, e_acq_v, e_unc_v, e_last; logic [1:0] e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t idleVec();
    vec_t v;
    v = '{default: 0};
    v.d_size = 3'd2;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    tl_d_t d;
    @(negedge clk);
    d        = '0;
    d.opcode = v.d_op;
    d.size   = v.d_size;
    d.source = v.d_src;
    d.data   = 32'hD00D_0000 | 32'(v.d_op);
    bus.acq_a_valid = v.acq_v;
    bus.acq_a       = acq_pay;
    bus.unc_a_valid = v.unc_v;
    bus.unc_a       = unc_pay;
    bus.tl_a_ready  = v.a_rdy;
    bus.tl_d_valid  = v.d_v;
    bus.tl_d        = d;
    bus.inv_d_ready = v.inv_r;
    bus.acq_d_ready = v.acq_r;
    bus.unc_d_ready = v.unc_r;
    #2;
  endtask

  task automatic checkVector(input vec_t v, input int idx);
    string p;
    p = $sformatf("vec%0d", idx);
    checkOutput({p, " tl_a_valid"}, 128'(bus.tl_a_valid), 128'(v.e_a_v));
    checkOutput({p, " tl_a.address"}, 128'(bus.tl_a.address), 128'(v.e_addr));
    checkOutput({p, " tl_a.source"}, 128'(bus.tl_a.source), 128'(v.e_a_src));
    checkOutput({p, " acq_a_ready"}, 128'(bus.acq_a_ready), 128'(v.e_acq_rdy));
    checkOutput({p, " unc_a_ready"}, 128'(bus.unc_a_ready), 128'(v.e_unc_rdy));
    checkOutput({p, " tl_d_ready"}, 128'(bus.tl_d_ready), 128'(v.e_d_rdy));
    checkOutput({p, " d_valids"},
                128'({bus.inv_d_valid, bus.acq_d_valid, bus.unc_d_valid}),
                128'({v.e_inv_v, v.e_acq_v, v.e_unc_v}));
    checkOutput({p, " d_last_o"}, 128'(bus.d_last_o), 128'(v.e_last));
    checkOutput({p, " err_o"}, 128'(bus.err_o), 128'(v.e_err));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(idleVec());
    applyStimulus(idleVec());
    rst = 1'b0;
  endtask

  vec_t v;

  // Randomized phase state: pending requests, stalled owner, current D message.
  tl_a_t      apay[2];
  bit         apend[2];
  int         hold;
  bit         m_act;
  int         m_op, m_size, m_src, m_beats, m_idx;
  logic [31:0] m_data;
  logic [1:0] err_m;
  int         ops[5] = '{0, 1, 4, 5, 6};

  initial begin
    acq_pay = '0; acq_pay.address = 32'hA000_0000; acq_pay.source = 2'd3; acq_pay.opcode = A_ACQUIRE_BLOCK;
    unc_pay = '0; unc_pay.address = 32'hB000_0000; unc_pay.source = 2'd2; unc_pay.opcode = A_GET;
    rst = 1'b1;

    // Valid/ready outputs are forced low while reset is asserted.
    v = idleVec();
    v.acq_v = 1; v.a_rdy = 1; v.d_v = 1; v.acq_r = 1; v.inv_r = 1; v.unc_r = 1;
    applyStimulus(v);
    checkOutput("rst tl_a_valid", 128'(bus.tl_a_valid), 128'(0));
    checkOutput("rst acq_a_ready", 128'(bus.acq_a_ready), 128'(0));
    checkOutput("rst tl_d_ready", 128'(bus.tl_d_ready), 128'(0));
    checkOutput("rst acq_d_valid", 128'(bus.acq_d_valid), 128'(0));
    applyStimulus(idleVec());
    rst = 1'b0;
    applyStimulus(idleVec());
    checkOutput("post-rst err_o", 128'(bus.err_o), 128'(0));
    checkOutput("post-rst d_last_o", 128'(bus.d_last_o), 128'(1));

    //                acq unc ardy dv op size src inv acq unc  eav addr          asrc ardy urdy drdy inv acq unc last err
    vecs.push_back('{1, 1, 1,   0, 0, 2, 0,  1, 1, 1,   1, 32'hA000_0000, 0, 1, 0,   1, 0, 0, 0, 1, 0});
    vecs.push_back('{0, 1, 1,   0, 0, 2, 0,  1, 1, 1,   1, 32'hB000_0000, 1, 0, 1,   1, 0, 0, 0, 1, 0});
    vecs.push_back('{0, 1, 0,   0, 0, 2, 0,  1, 1, 1,   1, 32'hB000_0000, 1, 0, 0,   1, 0, 0, 0, 1, 0});
    vecs.push_back('{1, 1, 0,   0, 0, 2, 0,  1, 1, 1,   1, 32'hB000_0000, 1, 0, 0,   1, 0, 0, 0, 1, 0});
    vecs.push_back('{1, 1, 0,   0, 0, 2, 0,  1, 1, 1,   1, 32'hB000_0000, 1, 0, 0,   1, 0, 0, 0, 1, 0});
    vecs.push_back('{1, 1, 1,   0, 0, 2, 0,  1, 1, 1,   1, 32'hB000_0000, 1, 0, 1,   1, 0, 0, 0, 1, 0});
    vecs.push_back('{1, 0, 1,   0, 0, 2, 0,  1, 1, 1,   1, 32'hA000_0000, 0, 1, 0,   1, 0, 0, 0, 1, 0});
    vecs.push_back('{0, 0, 0,   1, 6, 2, 2,  1, 0, 0,   0, 32'hA000_0000, 0, 0, 0,   1, 1, 0, 0, 1, 0});
    vecs.push_back('{0, 0, 0,   1, 5, 4, 0,  0, 1, 0,   0, 32'hA000_0000, 0, 0, 0,   1, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0,   1, 5, 4, 0,  0, 0, 0,   0, 32'hA000_0000, 0, 0, 0,   0, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0,   1, 5, 4, 0,  0, 1, 0,   0, 32'hA000_0000, 0, 0, 0,   1, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0,   1, 5, 4, 0,  0, 0, 0,   0, 32'hA000_0000, 0, 0, 0,   0, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0,   1, 5, 4, 0,  0, 1, 0,   0, 32'hA000_0000, 0, 0, 0,   1, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0,   1, 5, 4, 0,  0, 1, 0,   0, 32'hA000_0000, 0, 0, 0,   1, 0, 1, 0, 1, 0});
    vecs.push_back('{0, 0, 0,   1, 0, 2, 1,  0, 0, 1,   0, 32'hA000_0000, 0, 0, 0,   1, 0, 0, 1, 1, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkVector(vecs[i], i);
    end

    // Illegal source: sunk, flags err_o[0] until reset.
    v = idleVec(); v.d_v = 1; v.d_src = 2'd3;
    applyStimulus(v);
    checkOutput("illegal tl_d_ready", 128'(bus.tl_d_ready), 128'(1));
    checkOutput("illegal d_valids",
                128'({bus.inv_d_valid, bus.acq_d_valid, bus.unc_d_valid}), 128'(0));
    applyStimulus(idleVec());
    checkOutput("illegal err_o set", 128'(bus.err_o), 128'(2'b01));
    for (int i = 0; i < 3; i++) applyStimulus(idleVec());
    checkOutput("illegal err_o sticky", 128'(bus.err_o), 128'(2'b01));
    doReset();
    checkOutput("illegal err_o cleared", 128'(bus.err_o), 128'(2'b00));

    // Source switch on beat 2 of a GrantData burst restarts the count.
    v = idleVec(); v.d_v = 1; v.d_op = D_GRANT_DATA; v.d_size = 3'd4; v.d_src = 2'd0; v.acq_r = 1;
    applyStimulus(v);
    checkOutput("burst beat1 d_last_o", 128'(bus.d_last_o), 128'(0));
    v.d_src = 2'd1; v.acq_r = 0; v.unc_r = 1;
    applyStimulus(v);
    checkOutput("switch d_valids",
                128'({bus.inv_d_valid, bus.acq_d_valid, bus.unc_d_valid}), 128'(3'b001));
    checkOutput("switch d_last_o", 128'(bus.d_last_o), 128'(0));
    for (int b = 1; b < 4; b++) begin
      applyStimulus(v);
      if (b == 1) checkOutput("switch err_o", 128'(bus.err_o), 128'(2'b10));
      checkOutput($sformatf("restart beat%0d d_last_o", b + 1), 128'(bus.d_last_o),
                  128'(b == 3));
    end
    applyStimulus(idleVec());
    checkOutput("switch err_o sticky", 128'(bus.err_o), 128'(2'b10));

    // Reset in the middle of a burst drops the partial message.
    doReset();
    v = idleVec(); v.d_v = 1; v.d_op = D_GRANT_DATA; v.d_size = 3'd4; v.acq_r = 1;
    applyStimulus(v);
    doReset();
    v = idleVec(); v.d_v = 1; v.d_src = 2'd1; v.unc_r = 1;
    applyStimulus(v);
    checkOutput("rst mid-burst d_last_o", 128'(bus.d_last_o), 128'(1));
    applyStimulus(idleVec());
    checkOutput("rst mid-burst err_o", 128'(bus.err_o), 128'(0));

    // Randomized traffic against a message-level reference.
    doReset();
    hold = -1; apend[0] = 0; apend[1] = 0; m_act = 0; err_m = 2'b00;
    apay[0] = acq_pay; apay[1] = unc_pay; m_data = 32'h0;
    m_op = 0; m_size = 0; m_src = 0; m_beats = 1; m_idx = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [95:0] rv;
      logic        a_rdy, dv, inv_r, acq_r, unc_r, e_av, rd, e_last;
      int          g;
      tl_a_t       e_pay;
      tl_d_t       td;
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        if (!apend[r] && $urandom_range(2) == 0) begin
          rv = {$urandom(), $urandom(), $urandom()};
          apend[r] = 1'b1;
          apay[r]  = rv[78:0];
        end
      end
      if (!m_act && $urandom_range(2) == 0) begin
        m_act   = 1'b1;
        m_src   = ($urandom_range(7) == 0) ? 3 : int'($urandom_range(2));
        m_op    = ops[$urandom_range(4)];
        m_size  = ($urandom_range(1) == 1) ? 4 : 2;
        m_beats = ((m_op == 1 || m_op == 5) && (1 << m_size) == LINE_BYTES) ?
                  LINE_BYTES / BEAT_BYTES : 1;
        m_idx   = 0;
        m_data  = $urandom();
      end
      a_rdy = 1'($urandom_range(1));
      dv    = m_act && ($urandom_range(3) != 0);
      inv_r = 1'($urandom_range(1));
      acq_r = 1'($urandom_range(1));
      unc_r = 1'($urandom_range(1));
      td = '0;
      if (m_act) begin
        td.opcode = 3'(m_op); td.size = 3'(m_size); td.source = 2'(m_src); td.data = m_data;
      end
      bus.acq_a_valid = apend[0]; bus.acq_a = apay[0];
      bus.unc_a_valid = apend[1]; bus.unc_a = apay[1];
      bus.tl_a_ready  = a_rdy;
      bus.tl_d_valid  = dv; bus.tl_d = td;
      bus.inv_d_ready = inv_r; bus.acq_d_ready = acq_r; bus.unc_d_ready = unc_r;
      #2;
      g = (hold >= 0) ? hold : (apend[0] ? 0 : (apend[1] ? 1 : 0));
      e_av = apend[g];
      e_pay = apay[g];
      e_pay.source = (g == 0) ? TL_SRC_ACQ : TL_SRC_UNC;
      case (td.source)
        2'd0:    rd = acq_r;
        2'd1:    rd = unc_r;
        2'd2:    rd = inv_r;
        default: rd = 1'b1;
      endcase
      e_last = m_act ? (m_idx == m_beats - 1) : 1'b1;
      checkOutput($sformatf("rnd%0d tl_a_valid", cyc), 128'(bus.tl_a_valid), 128'(e_av));
      checkOutput($sformatf("rnd%0d tl_a", cyc), 128'(bus.tl_a), 128'(e_pay));
      checkOutput($sformatf("rnd%0d a_readies", cyc),
                  128'({bus.acq_a_ready, bus.unc_a_ready}),
                  128'({(g == 0) && a_rdy, (g == 1) && a_rdy}));
      checkOutput($sformatf("rnd%0d tl_d_ready", cyc), 128'(bus.tl_d_ready), 128'(rd));
      checkOutput($sformatf("rnd%0d d_valids", cyc),
                  128'({bus.inv_d_valid, bus.acq_d_valid, bus.unc_d_valid}),
                  128'({dv && td.source == 2'd2, dv && td.source == 2'd0, dv && td.source == 2'd1}));
      checkOutput($sformatf("rnd%0d d_o", cyc), 128'(bus.d_o), 128'(td));
      checkOutput($sformatf("rnd%0d d_last_o", cyc), 128'(bus.d_last_o), 128'(e_last));
      checkOutput($sformatf("rnd%0d err_o", cyc), 128'(bus.err_o), 128'(err_m));
      if (e_av && a_rdy) begin
        apend[g] = 1'b0;
        hold     = -1;
      end else if (e_av) begin
        hold = g;
      end
      if (dv && rd) begin
        if (m_src == 3) err_m[0] = 1'b1;
        m_idx++;
        m_data = $urandom();
        if (m_idx == m_beats) m_act = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
